// File: rtl/shfifo_rd_drain.sv
// shfifo_rd_drain: drains a registered-flag FIFO into a valid/ready
// stream through a 2-entry head/skid buffer with a transfer counter.
module shfifo_rd_drain #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drain_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdat,
  output logic              fifo_ren,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              idle
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e              r_state;
  occ_e              w_state_nxt;
  logic              r_inflight;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_skid;
  logic [CNT_W-1:0]  r_xfer_cnt;

  logic              w_pop;
  logic              w_land;
  logic [1:0]        w_occ;
  logic [1:0]        w_occ_commit;
  logic [1:0]        w_budget;

  assign w_occ        = r_state;
  assign w_pop        = (w_occ != 2'd0) && m_ready;
  assign w_land       = r_inflight;
  assign w_occ_commit = w_occ - {1'b0, w_pop};
  assign w_budget     = w_occ_commit + {1'b0, r_inflight};

  // A read is only issued when its word is sure to find a free slot.
  assign fifo_ren = !rst && drain_en && !fifo_empty
                    && (w_budget < 2'd2);

  assign m_valid  = (w_occ != 2'd0);
  assign m_data   = r_head;
  assign occ      = w_occ;
  assign xfer_cnt = r_xfer_cnt;
  assign idle     = !r_inflight && (w_occ == 2'd0);

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy next state: +1 on land, -1 on pop, both cancel.
  always_comb begin
    w_state_nxt = r_state;
    case ({w_land, w_pop})
      2'b10: begin
        case (r_state)
          EMPTY:   w_state_nxt = ONE;
          ONE:     w_state_nxt = TWO;
          default: w_state_nxt = TWO;
        endcase
      end
      2'b01: begin
        case (r_state)
          TWO:     w_state_nxt = ONE;
          ONE:     w_state_nxt = EMPTY;
          default: w_state_nxt = EMPTY;
        endcase
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // In-flight flag tracks the read issued last cycle; reset drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_ren;
    end
  end

  // Head/skid data: skid promotes on pop, landing word fills the
  // head if it is free after the pop, else the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_pop && (r_state == TWO)) begin
        r_head <= r_skid;
      end
      if (w_land) begin
        if (w_occ_commit == 2'd0) begin
          r_head <= fifo_rdat;
        end else begin
          r_skid <= fifo_rdat;
        end
      end
    end
  end

  // Completed-transfer counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (w_pop) begin
      r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_shfifo_rd_drain.sv
// tb_shfifo_rd_drain: directed scenarios with a queue-based FIFO and
// an in-order scoreboard of words read from that FIFO.
module tb_shfifo_rd_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drain_en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_rdat = 32'h0;
  logic        fifo_ren;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [1:0]  occ;
  logic [3:0]  xfer_cnt;
  logic        idle;

  shfifo_rd_drain #(.DATA_W(32), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .drain_en  (drain_en),
    .fifo_empty(fifo_empty),
    .fifo_rdat (fifo_rdat),
    .fifo_ren  (fifo_ren),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occ       (occ),
    .xfer_cnt  (xfer_cnt),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  logic [31:0] fq[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cnt_model = 0;
  int          ren_cnt = 0;
  int          vld_cnt = 0;
  logic        xfer_now = 1'b0;
  logic        ren_now = 1'b0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = 32'h0;

  // FIFO model: one-cycle read latency, registered empty flag.
  always @(posedge clk) begin
    if (fifo_ren && fq.size() > 0) begin
      fifo_rdat <= fq[0];
      exp_q.push_back(fq[0]);
      void'(fq.pop_front());
    end else begin
      fifo_rdat <= $urandom();
    end
    fifo_empty <= (fq.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    xfer_now = m_valid && m_ready;
    ren_now  = fifo_ren;
    chk("ren_while_empty", {31'b0, fifo_ren & fifo_empty}, 32'h0);
    if (fifo_ren) ren_cnt++;
    if (m_valid) vld_cnt++;
    if (hold_v) begin
      chk("hold_valid", {31'b0, m_valid}, 32'h1);
      chk("hold_data", m_data, hold_d);
    end
    if (xfer_now) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'h0, 32'h1);
      end else begin
        chk("m_data_order", m_data, exp_q.pop_front());
      end
      cnt_model++;
    end
    hold_v = m_valid && !m_ready && !rst;
    hold_d = m_data;
    @(posedge clk);
    #1;
    chk("xfer_cnt", {28'b0, xfer_cnt}, cnt_model % 16);
    chk("occ_range", {31'b0, occ <= 2'd2}, 32'h1);
    chk("mvalid_occ", {31'b0, m_valid}, {31'b0, occ != 2'd0});
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if (fq.size() == 0 && fifo_empty && idle && exp_q.size() == 0)
        break;
      tick();
    end
    chk("drain_idle", {31'b0, idle}, 32'h1);
    chk("drain_sb", exp_q.size(), 32'h0);
  endtask

  int base_ren;
  int base_cnt;
  int base_vld;

  initial begin
    // Reset with FIFO preloaded and drain enabled.
    rst = 1'b1;
    drain_en = 1'b1;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) fq.push_back(32'(i));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ren", {31'b0, fifo_ren}, 32'h0);
      chk("rst_mvalid", {31'b0, m_valid}, 32'h0);
      chk("rst_mdata", m_data, 32'h0);
      chk("rst_idle", {31'b0, idle}, 32'h1);
      chk("rst_occ", {30'b0, occ}, 32'h0);
    end
    rst = 1'b0;
    m_ready = 1'b1;
    chk("post_rst_mvalid", {31'b0, m_valid}, 32'h0);
    chk("post_rst_idle", {31'b0, idle}, 32'h1);

    // Streaming at full rate.
    for (int i = 0; i < 10; i++) begin
      tick();
      if (xfer_now) break;
    end
    chk("stream_start", {31'b0, xfer_now}, 32'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("stream_b2b", {31'b0, xfer_now}, 32'h1);
    end
    drain();
    chk("stream_cnt", {28'b0, xfer_cnt}, 32'd8);

    // Backpressure.
    m_ready = 1'b0;
    base_ren = ren_cnt;
    for (int i = 0; i < 4; i++) fq.push_back(32'h10 + 32'(i));
    for (int i = 0; i < 8; i++) tick();
    chk("bp_reads", ren_cnt - base_ren, 32'd2);
    chk("bp_occ", {30'b0, occ}, 32'd2);
    chk("bp_head", m_data, 32'h10);
    m_ready = 1'b1;
    drain();
    chk("bp_cnt", {28'b0, xfer_cnt}, 32'd12);

    // Single word at the empty boundary.
    base_ren = ren_cnt;
    fq.push_back(32'hA5);
    tick();
    chk("lat_e0", {31'b0, m_valid}, 32'h0);
    tick();
    chk("lat_e1", {31'b0, m_valid}, 32'h0);
    tick();
    chk("lat_e2", {31'b0, m_valid}, 32'h1);
    chk("one_data", m_data, 32'hA5);
    drain();
    chk("one_reads", ren_cnt - base_ren, 32'd1);
    chk("one_cnt", {28'b0, xfer_cnt}, 32'd13);

    // drain_en falls right after a read.
    for (int i = 0; i < 6; i++) fq.push_back(32'h20 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ren_now) break;
    end
    chk("dd_first_ren", {31'b0, ren_now}, 32'h1);
    drain_en = 1'b0;
    base_ren = ren_cnt;
    base_cnt = cnt_model;
    for (int i = 0; i < 8; i++) tick();
    chk("dd_no_ren", ren_cnt - base_ren, 32'd0);
    chk("dd_emitted", cnt_model - base_cnt, 32'd1);
    chk("dd_idle", {31'b0, idle}, 32'h1);
    chk("dd_left", fq.size(), 32'd5);
    drain_en = 1'b1;
    drain();
    chk("dd_cnt", {28'b0, xfer_cnt}, 32'd3);

    // Reset mid-stream with a read in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(32'h30 + 32'(i));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (occ == 2'd2) break;
    end
    chk("mr_full", {30'b0, occ}, 32'd2);
    m_ready = 1'b1;
    tick();
    chk("mr_occ1", {30'b0, occ}, 32'd1);
    chk("mr_inflight", {31'b0, idle}, 32'h0);
    rst = 1'b1;
    m_ready = 1'b0;
    hold_v = 1'b0;
    fq.delete();
    exp_q.delete();
    cnt_model = 0;
    tick();
    chk("mr_occ0", {30'b0, occ}, 32'd0);
    chk("mr_mvalid", {31'b0, m_valid}, 32'h0);
    chk("mr_cnt", {28'b0, xfer_cnt}, 32'd0);
    chk("mr_mdata", m_data, 32'h0);
    rst = 1'b0;
    m_ready = 1'b1;
    base_vld = vld_cnt;
    for (int i = 0; i < 6; i++) tick();
    chk("mr_no_stale", vld_cnt - base_vld, 32'd0);
    fq.push_back(32'h40);
    fq.push_back(32'h41);
    drain();
    chk("mr_cnt2", {28'b0, xfer_cnt}, 32'd2);

    // Counter wrap at 4 bits: 17 transfers since reset.
    for (int i = 0; i < 15; i++) fq.push_back($urandom());
    drain();
    chk("wrap_cnt", {28'b0, xfer_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
